// File: rtl/adc_sample_packer.sv
// ADC/GPIO sample packer: captures both ADC channels and the GPIO bus every
// cycle, packs them into 32-bit FIFO words by mode, and counts words dropped
// while the FIFO is full. Everything runs in the ADC clock domain.
module adc_sample_packer #(
    parameter int CNT_W       = 16,
    parameter int SYNC_STAGES = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [11:0]      adc0_data,
    input  logic [11:0]      adc1_data,
    input  logic [7:0]       gpio_data,
    input  logic [1:0]       mode_in,
    input  logic             enable_in,
    input  logic             clr_overflow,
    input  logic             fifo_full,
    output logic [31:0]      fifo_wdata,
    output logic             fifo_winc,
    output logic             overflow,
    output logic [CNT_W-1:0] overflow_count,
    output logic [1:0]       mode_active
);

    typedef enum logic {PH_LO = 1'b0, PH_HI = 1'b1} phase_t;

    logic [SYNC_STAGES-1:0][1:0] mode_sync;
    logic [SYNC_STAGES-1:0]      en_sync;
    logic [11:0]                 adc0_s1, adc1_s1;
    logic [7:0]                  gpio_s1;

    phase_t      phase, phase_nxt;
    logic [15:0] low_half, low_half_nxt;
    logic [31:0] test_cnt, test_cnt_nxt;
    logic        en_active;
    logic [15:0] half_sel;
    logic [31:0] word;
    logic        word_rdy, drop, wr, boundary;
    logic [CNT_W-1:0] ovf_cnt_nxt;
    logic             ovf_nxt;

    // Settings come from a foreign domain; pass them through a flop chain.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mode_sync <= '0;
            en_sync   <= '0;
        end else begin
            mode_sync <= {mode_sync[SYNC_STAGES-2:0], mode_in};
            en_sync   <= {en_sync[SYNC_STAGES-2:0], enable_in};
        end
    end

    // S1: register raw samples every cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            adc0_s1 <= '0;
            adc1_s1 <= '0;
            gpio_s1 <= '0;
        end else begin
            adc0_s1 <= adc0_data;
            adc1_s1 <= adc1_data;
            gpio_s1 <= gpio_data;
        end
    end

    // Pack step: form the next word from S1 under the applied mode/enable.
    always_comb begin
        word_rdy     = 1'b0;
        word         = '0;
        phase_nxt    = phase;
        low_half_nxt = low_half;
        test_cnt_nxt = test_cnt;
        half_sel     = (mode_active == 2'd2) ? {gpio_s1[7:4], adc1_s1}
                                             : {gpio_s1[3:0], adc0_s1};
        if (en_active) begin
            case (mode_active)
                2'd0: begin
                    word_rdy = 1'b1;
                    word     = {adc1_s1, gpio_s1, adc0_s1};
                end
                2'd1, 2'd2: begin
                    if (phase == PH_LO) begin
                        low_half_nxt = half_sel;
                        phase_nxt    = PH_HI;
                    end else begin
                        word_rdy  = 1'b1;
                        word      = {half_sel, low_half};
                        phase_nxt = PH_LO;
                    end
                end
                default: begin
                    word_rdy     = 1'b1;
                    word         = test_cnt;
                    test_cnt_nxt = test_cnt + 32'd1;
                end
            endcase
        end else begin
            phase_nxt = PH_LO;
        end
        drop = word_rdy & fifo_full;
        wr   = word_rdy & ~fifo_full;
        // New settings may only take over once no half-word is pending.
        boundary = (phase_nxt == PH_LO);
    end

    // Drop accounting: a drop in the same cycle as a clear restarts at 1.
    always_comb begin
        ovf_nxt     = overflow;
        ovf_cnt_nxt = overflow_count;
        if (drop) begin
            ovf_nxt     = 1'b1;
            ovf_cnt_nxt = clr_overflow ? CNT_W'(1)
                        : (&overflow_count) ? overflow_count
                        : overflow_count + CNT_W'(1);
        end else if (clr_overflow) begin
            ovf_nxt     = 1'b0;
            ovf_cnt_nxt = '0;
        end
    end

    // S2 and pack state registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            phase          <= PH_LO;
            low_half       <= '0;
            test_cnt       <= '0;
            en_active      <= 1'b0;
            mode_active    <= 2'd0;
            fifo_wdata     <= '0;
            fifo_winc      <= 1'b0;
            overflow       <= 1'b0;
            overflow_count <= '0;
        end else begin
            phase          <= phase_nxt;
            low_half       <= low_half_nxt;
            test_cnt       <= test_cnt_nxt;
            fifo_winc      <= wr;
            overflow       <= ovf_nxt;
            overflow_count <= ovf_cnt_nxt;
            if (wr) fifo_wdata <= word;
            if (boundary) begin
                en_active   <= en_sync[SYNC_STAGES-1];
                mode_active <= mode_sync[SYNC_STAGES-1];
            end
        end
    end

endmodule

// File: tb/tb_adc_sample_packer.sv
// Bench for adc_sample_packer: lockstep reference model plus directed vectors.
module tb_adc_sample_packer;
    localparam int CNT_W = 4;
    localparam int SYNC  = 2;
    localparam logic [CNT_W-1:0] CMAX = '1;

    logic clk = 0, rst = 1;
    logic [11:0] adc0_data = 0, adc1_data = 0;
    logic [7:0]  gpio_data = 0;
    logic [1:0]  mode_in = 0;
    logic enable_in = 0, clr_overflow = 0, fifo_full = 0;
    logic [31:0] fifo_wdata;
    logic fifo_winc, overflow;
    logic [CNT_W-1:0] overflow_count;
    logic [1:0] mode_active;

    int checks = 0, errors = 0;

    adc_sample_packer #(.CNT_W(CNT_W), .SYNC_STAGES(SYNC)) dut (
        .clk(clk), .rst(rst), .adc0_data(adc0_data), .adc1_data(adc1_data),
        .gpio_data(gpio_data), .mode_in(mode_in), .enable_in(enable_in),
        .clr_overflow(clr_overflow), .fifo_full(fifo_full),
        .fifo_wdata(fifo_wdata), .fifo_winc(fifo_winc), .overflow(overflow),
        .overflow_count(overflow_count), .mode_active(mode_active));

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h t=%0t", name, act, exp, $time);
        end
    endtask

    // Reference model: settings delayed through queues, a pending-half flag
    // instead of a phase, and words built straight from the mode rules.
    logic [1:0]  mq[$];
    logic        eq[$];
    logic [1:0]  m_mode;
    logic        m_en, m_have_half, m_winc, m_ovf;
    logic [15:0] m_half;
    logic [31:0] m_ctr, m_wdata;
    logic [CNT_W-1:0] m_cnt;
    logic [11:0] m_a0, m_a1;
    logic [7:0]  m_g;

    task automatic model_reset();
        mq = {}; eq = {};
        for (int i = 0; i < SYNC; i++) begin mq.push_back(2'd0); eq.push_back(1'b0); end
        m_mode = 0; m_en = 0; m_have_half = 0; m_winc = 0; m_ovf = 0;
        m_half = 0; m_ctr = 0; m_wdata = 0; m_cnt = 0; m_a0 = 0; m_a1 = 0; m_g = 0;
    endtask

    task automatic model_step();
        logic [31:0] w;
        logic [15:0] h;
        bit rdy;
        rdy = 0; w = 0;
        if (m_en) begin
            if (m_mode == 2'd0) begin
                rdy = 1; w = {m_a1, m_g, m_a0};
            end else if (m_mode == 2'd3) begin
                rdy = 1; w = m_ctr; m_ctr = m_ctr + 1;
            end else begin
                h = (m_mode == 2'd1) ? {m_g[3:0], m_a0} : {m_g[7:4], m_a1};
                if (!m_have_half) begin m_half = h; m_have_half = 1; end
                else begin rdy = 1; w = {h, m_half}; m_have_half = 0; end
            end
        end
        m_winc = rdy && !fifo_full;
        if (m_winc) m_wdata = w;
        if (rdy && fifo_full) begin
            m_ovf = 1;
            m_cnt = clr_overflow ? CNT_W'(1) : (m_cnt == CMAX ? CMAX : m_cnt + 1'b1);
        end else if (clr_overflow) begin
            m_ovf = 0; m_cnt = 0;
        end
        if (!m_have_half) begin m_mode = mq[$]; m_en = eq[$]; end
        mq.push_front(mode_in); void'(mq.pop_back());
        eq.push_front(enable_in); void'(eq.pop_back());
        m_a0 = adc0_data; m_a1 = adc1_data; m_g = gpio_data;
    endtask

    initial model_reset();

    // Lockstep compare just after every rising edge.
    always @(posedge clk) begin
        if (rst) model_reset();
        else model_step();
        #1;
        chk("model_winc", fifo_winc, m_winc);
        chk("model_wdata", fifo_wdata, m_wdata);
        chk("model_overflow", overflow, m_ovf);
        chk("model_count", overflow_count, m_cnt);
        chk("model_mode_active", mode_active, m_mode);
    end

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    typedef struct {
        logic [1:0]  mode;
        logic [11:0] a0, a1;
        logic [7:0]  g;
        logic [31:0] exp;
    } vec_t;
    vec_t tbl[5];

    initial begin
        #1_000_000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        int n, prev, v;
        bit hit;
        tbl[0] = '{2'd0, 12'h123, 12'hABC, 8'h5A, 32'hABC5A123};
        tbl[1] = '{2'd1, 12'h7FF, 12'h000, 8'h3C, 32'hC7FFC7FF};
        tbl[2] = '{2'd2, 12'h000, 12'h456, 8'hA5, 32'hA456A456};
        tbl[3] = '{2'd0, 12'hFFF, 12'hFFF, 8'hFF, 32'hFFFFFFFF};
        tbl[4] = '{2'd0, 12'h000, 12'h001, 8'h80, 32'h00180000};

        // Reset state
        cyc(3);
        chk("rst_winc", fifo_winc, 0);
        chk("rst_wdata", fifo_wdata, 0);
        chk("rst_overflow", overflow, 0);
        chk("rst_count", overflow_count, 0);
        chk("rst_mode", mode_active, 0);
        rst = 0;
        cyc(2);
        chk("disabled_winc", fifo_winc, 0);

        // Steady-state packing vectors
        enable_in = 1;
        foreach (tbl[i]) begin
            mode_in = tbl[i].mode; adc0_data = tbl[i].a0;
            adc1_data = tbl[i].a1; gpio_data = tbl[i].g;
            cyc(8);
            hit = 0;
            for (int k = 0; k < 10 && !hit; k++) begin
                if (fifo_winc) hit = 1; else cyc(1);
            end
            chk($sformatf("tbl%0d_winc", i), hit, 1);
            chk($sformatf("tbl%0d_word", i), fifo_wdata, tbl[i].exp);
        end

        // Mode 1 pair alignment from a clean enable
        enable_in = 0; mode_in = 1; gpio_data = 8'h0F; cyc(8);
        enable_in = 1; adc0_data = 12'h001;
        n = 0;
        for (int k = 0; k < 24; k++) begin
            cyc(1);
            adc0_data = (adc0_data == 12'h001) ? 12'h002 : 12'h001;
            if (fifo_winc) begin
                n++;
                if (n == 1) chk("m1_word", fifo_wdata, 32'hF002F001);
            end
        end
        chk("m1_duty", n, 10);

        // Mode change 1->0 only lands together with a completed pair
        cyc(1);
        mode_in = 0;
        prev = mode_active; hit = 0;
        for (int k = 0; k < 20 && !hit; k++) begin
            cyc(1);
            if (prev == 1 && mode_active == 0) begin
                hit = 1;
                chk("m1to0_pair_done", fifo_winc, 1);
            end
            prev = mode_active;
        end
        chk("m1to0_switched", hit, 1);

        // Mode 3: three dropped slots show as a +4 jump
        mode_in = 3; cyc(8);
        clr_overflow = 1; cyc(1); clr_overflow = 0; cyc(1);
        chk("m3_clear", overflow, 0);
        chk("m3_winc", fifo_winc, 1);
        v = fifo_wdata;
        fifo_full = 1;
        for (int k = 0; k < 3; k++) begin
            cyc(1);
            chk("m3_hold_winc", fifo_winc, 0);
        end
        fifo_full = 0; cyc(1);
        chk("m3_resume_winc", fifo_winc, 1);
        chk("m3_jump", fifo_wdata, v + 4);
        chk("m3_overflow", overflow, 1);
        chk("m3_count", overflow_count, 3);

        // Clear coinciding with a drop
        fifo_full = 1; cyc(2);
        clr_overflow = 1; cyc(1);
        clr_overflow = 0; fifo_full = 0; cyc(1);
        chk("clr_drop_overflow", overflow, 1);
        chk("clr_drop_count", overflow_count, 1);

        // Saturation
        fifo_full = 1; cyc(20);
        chk("sat_count", overflow_count, CMAX);
        fifo_full = 0; clr_overflow = 1; cyc(1); clr_overflow = 0; cyc(1);
        chk("sat_cleared", overflow_count, 0);

        // Reset in phase 1 of mode 2
        mode_in = 2; cyc(8);
        hit = 0;
        for (int k = 0; k < 6 && !hit; k++) begin
            if (fifo_winc) hit = 1; else cyc(1);
        end
        chk("m2_winc_seen", hit, 1);
        cyc(1);
        rst = 1; enable_in = 0;
        #1;
        chk("async_rst_winc", fifo_winc, 0);
        chk("async_rst_wdata", fifo_wdata, 0);
        chk("async_rst_mode", mode_active, 0);
        cyc(2);
        rst = 0;
        n = 0;
        for (int k = 0; k < 10; k++) begin cyc(1); if (fifo_winc) n++; end
        chk("post_rst_no_winc", n, 0);
        enable_in = 1;
        n = 0;
        for (int k = 1; k <= 12 && n == 0; k++) begin
            cyc(1);
            if (fifo_winc) n = k;
        end
        chk("post_rst_en_latency", n, 5);

        // Randomized run against the model
        for (int k = 0; k < 1500; k++) begin
            cyc(1);
            adc0_data = 12'($urandom); adc1_data = 12'($urandom);
            gpio_data = 8'($urandom);
            if ($urandom_range(0, 29) == 0) mode_in = 2'($urandom);
            if ($urandom_range(0, 39) == 0) enable_in = ~enable_in;
            fifo_full = ($urandom_range(0, 3) == 0);
            clr_overflow = ($urandom_range(0, 15) == 0);
        end
        cyc(2);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/adc_sample_packer.md
Name: adc_sample_packer

Overview:
- Upstream write-side stage of the ADC-to-HDMI path; runs entirely in the ADC clock domain.
- Captures the two 12-bit ADC buses and the 8-bit GPIO bus every cycle and packs them into 32-bit words according to a selectable mode.
- Drives the async FIFO write port: data, write strobe, and full feedback.
- Detects and counts samples dropped on FIFO full so the host can see capture gaps.

Parameters:
- CNT_W, 16, width of saturating overflow counter
- SYNC_STAGES, 2, flip-flop stages on mode/enable inputs (min 2)

Ports:
- clk  in  1  ADC sample clock; all logic on rising edge
- rst  in  1  asynchronous, active-high reset
- adc0_data  in  12  ADC channel 0 sample
- adc1_data  in  12  ADC channel 1 sample
- gpio_data  in  8  auxiliary digital inputs, sampled alongside ADC
- mode_in  in  2  packing mode from settings register (foreign domain, quasi-static)
- enable_in  in  1  capture enable from settings register (foreign domain)
- clr_overflow  in  1  single-cycle pulse in clk domain; clears sticky flag and counter
- fifo_full  in  1  FIFO write-side full
- fifo_wdata  out  32  packed word
- fifo_winc  out  1  write strobe, one word per high cycle
- overflow  out  1  sticky: at least one word dropped since reset/clear
- overflow_count  out  CNT_W  dropped-word count, saturating at all-ones
- mode_active  out  2  mode currently applied

Behaviour:
- Reset: all outputs 0, pack phase 0, test counter 0, sync chains 0, so mode_active=0 and capture disabled.
- Input stage: adc0/adc1/gpio registered every cycle (stage S1). Output word registered from S1 (stage S2). Sample at edge N appears on fifo_wdata/fifo_winc after edge N+2.
- mode_in and enable_in pass through SYNC_STAGES flops before use.
- Mode and enable changes are applied only at a word boundary: pack phase 0, or the cycle that completes a word. A half-filled pair is never emitted with mixed modes.
- Mode 0, dual:
  - Word = {adc1, gpio, adc0}.
  - winc every cycle while enabled.
- Mode 1, ADC0 only:
  - Half = {gpio[3:0], adc0}.
  - Phase 0 stores the low half. Phase 1 forms the word {half_phase1, half_phase0} and asserts winc.
  - One write per 2 cycles.
- Mode 2: same as mode 1 using adc1 and gpio[7:4].
- Mode 3, test:
  - Word = free-running 32-bit counter, incremented every enabled cycle whether or not the write succeeds.
  - Drops therefore appear as jumps in the sequence.
  - Counter wraps 0xFFFFFFFF -> 0.
- Disabled: fifo_winc=0, pack phase forced to 0, and the test counter holds. Disable takes effect at the next word boundary.
- Full handling:
  - If a word is ready while fifo_full=1, fifo_winc stays 0 and the word is discarded (no retry, no stall).
  - overflow is set and overflow_count increments by 1, saturating.
  - The pack phase advances normally.
- clr_overflow:
  - Clears overflow and count on the next edge.
  - If a drop occurs in the same cycle, the drop wins: overflow=1, count=1.
- Asynchronous reset mid-word discards any partial half immediately. No spurious winc on the first cycle after reset release.
- fifo_winc is never high for two consecutive cycles in modes 1 and 2.

Test Plan:
- Mode 0, enable=1, adc0=0x123, adc1=0xABC, gpio=0x5A -> fifo_wdata=0xABC5A123 with winc=1 every cycle; first word 2 cycles after the first sampled edge plus sync latency.
- Mode 1, adc0 sequence 0x001, 0x002, gpio=0x0F -> one word 0xF002F001, winc duty 1/2, no write on the odd phase.
- Mode 3 with fifo_full held high for 3 word slots -> no winc during the hold; overflow=1, overflow_count=3; the next written counter value is 3 greater than expected.
- mode_in changes 1->0 while in pack phase 1 -> current pair completes in mode 1; mode_active switches only after that word; no mixed word emitted.
- clr_overflow pulse in the same cycle as a drop -> overflow=1, overflow_count=1. Force the count to saturate with CNT_W=4 -> count stays at 0xF.
- Assert rst in phase 1 of mode 2 -> outputs 0 immediately. After release with enable=0 -> winc stays 0 until enable propagates through SYNC_STAGES.
